// File: rtl/tx_cmd_scheduler.sv
// tx_cmd_scheduler: round-robin dispatch of two requester FIFOs onto two TX engines with ack timeout.
module tx_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 25,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                         clock_clk,
  input  logic                         reset_reset_n,
  input  logic                         mac_inited,
  input  logic                         cal_success,
  input  logic                         req0_cmd_send,
  input  logic [ADDR_W-1:0]            req0_start_ram_addr,
  input  logic                         req1_cmd_send,
  input  logic [ADDR_W-1:0]            req1_start_ram_addr,
  input  logic                         tx0_busy,
  input  logic                         tx1_busy,
  output logic                         tx0_cmd_send,
  output logic                         tx1_cmd_send,
  output logic [ADDR_W-1:0]            tx0_start_ram_addr,
  output logic [ADDR_W-1:0]            tx1_start_ram_addr,
  output logic [$clog2(FIFO_DEPTH):0]  req0_level,
  output logic [$clog2(FIFO_DEPTH):0]  req1_level,
  output logic                         req0_overflow,
  output logic                         req1_overflow,
  input  logic                         ovf_clear,
  output logic                         tx0_timeout,
  output logic                         tx1_timeout
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, BUSY} st_t;
  logic [ADDR_W-1:0] mem_q [2][FIFO_DEPTH];
  logic [PW-1:0]     wp_q [2];
  logic [PW-1:0]     rp_q [2];
  logic [LW-1:0]     lvl_q [2];
  logic [CW-1:0]     cnt_q [2];
  logic [CW-1:0]     cnt_d [2];
  st_t               st_q [2];
  st_t               st_d [2];
  logic [ADDR_W-1:0] txa_q [2];
  logic [ADDR_W-1:0] waddr [2];
  logic [ADDR_W-1:0] head;
  logic [1:0]        push, wr, pop, ne, full, busy, send_q, ovf_q, to;
  logic              en, rr_q, sel, ch, disp;
  assign push     = {req1_cmd_send, req0_cmd_send};
  assign busy     = {tx1_busy, tx0_busy};
  assign waddr[0] = req0_start_ram_addr;
  assign waddr[1] = req1_start_ram_addr;
  always_comb begin
    en = mac_inited & cal_success;
    for (int i = 0; i < 2; i++) begin
      ne[i]   = lvl_q[i] != '0;
      full[i] = lvl_q[i] == LW'(FIFO_DEPTH);
    end
    sel  = rr_q ? ne[1] : ~ne[0];
    ch   = st_q[0] != IDLE;
    disp = en && (|ne) && (st_q[0] == IDLE || st_q[1] == IDLE);
    head = mem_q[sel][rp_q[sel]];
    pop  = disp ? (sel ? 2'b10 : 2'b01) : 2'b00;
    for (int i = 0; i < 2; i++)
      wr[i] = push[i] && (!full[i] || pop[i]);
    st_d  = st_q;
    cnt_d = cnt_q;
    to    = '0;
    // busy is ignored during the dispatch pulse cycle; the ack window starts the cycle after
    for (int k = 0; k < 2; k++) begin
      if (disp && int'(ch) == k) begin
        st_d[k]  = WAIT_ACK;
        cnt_d[k] = '0;
      end else if (st_q[k] == WAIT_ACK && !send_q[k]) begin
        if (busy[k]) st_d[k] = BUSY;
        else if (cnt_q[k] == CW'(ACK_TIMEOUT - 1)) begin
          to[k]   = 1'b1;
          st_d[k] = IDLE;
        end else cnt_d[k] = cnt_q[k] + 1'b1;
      end else if (st_q[k] == BUSY && !busy[k]) st_d[k] = IDLE;
    end
  end
  always_ff @(posedge clock_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_reset_n) begin
        wp_q[i]   <= '0;
        rp_q[i]   <= '0;
        lvl_q[i]  <= '0;
        ovf_q[i]  <= 1'b0;
        st_q[i]   <= IDLE;
        cnt_q[i]  <= '0;
        send_q[i] <= 1'b0;
        txa_q[i]  <= '0;
      end else begin
        if (wr[i]) begin
          mem_q[i][wp_q[i]] <= waddr[i];
          wp_q[i]           <= wp_q[i] + 1'b1;
        end
        if (pop[i]) rp_q[i] <= rp_q[i] + 1'b1;
        lvl_q[i]  <= lvl_q[i] + LW'(wr[i]) - LW'(pop[i]);
        ovf_q[i]  <= ovf_clear ? 1'b0 : ovf_q[i] | (push[i] & ~wr[i]);
        st_q[i]   <= st_d[i];
        cnt_q[i]  <= cnt_d[i];
        send_q[i] <= disp && int'(ch) == i;
        if (disp && int'(ch) == i) txa_q[i] <= head;
      end
    end
    if (!reset_reset_n) rr_q <= 1'b0;
    else if (disp) rr_q <= ~sel;
  end
  assign tx0_cmd_send       = send_q[0];
  assign tx1_cmd_send       = send_q[1];
  assign tx0_start_ram_addr = txa_q[0];
  assign tx1_start_ram_addr = txa_q[1];
  assign req0_level         = lvl_q[0];
  assign req1_level         = lvl_q[1];
  assign req0_overflow      = ovf_q[0];
  assign req1_overflow      = ovf_q[1];
  assign tx0_timeout        = to[0];
  assign tx1_timeout        = to[1];
endmodule

// File: tb/tb_tx_cmd_scheduler.sv
// tb_tx_cmd_scheduler: directed bench with simple TX engine models and a dispatch log.
module tb_tx_cmd_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, mac_inited = 1'b0, cal_success = 1'b0, ovf_clear = 1'b0;
  logic req0_cmd_send = 1'b0, req1_cmd_send = 1'b0;
  logic [24:0] req0_addr = '0, req1_addr = '0, tx0_addr, tx1_addr;
  logic tx0_busy, tx1_busy, tx0_cmd_send, tx1_cmd_send, tx0_timeout, tx1_timeout;
  logic req0_overflow, req1_overflow;
  logic [2:0] req0_level, req1_level;
  int n_vec = 0, n_mis = 0, cyc = 0, to0_n = 0, to1_n = 0, to0_cyc = 0, pc = 0;
  int bl [2] = '{5, 5};
  int bcnt [2] = '{0, 0};
  logic [1:0] noack = 2'b00;
  typedef struct packed {logic ch; logic [24:0] addr; int cyc;} disp_t;
  disp_t log_q [$];
  int exp_rr [8] = '{'h200, 'h100, 'h201, 'h101, 'h202, 'h102, 'h203, 'h103};

  tx_cmd_scheduler dut (
    .clock_clk(clk), .reset_reset_n(rst_n), .mac_inited(mac_inited), .cal_success(cal_success),
    .req0_cmd_send(req0_cmd_send), .req0_start_ram_addr(req0_addr),
    .req1_cmd_send(req1_cmd_send), .req1_start_ram_addr(req1_addr),
    .tx0_busy(tx0_busy), .tx1_busy(tx1_busy),
    .tx0_cmd_send(tx0_cmd_send), .tx1_cmd_send(tx1_cmd_send),
    .tx0_start_ram_addr(tx0_addr), .tx1_start_ram_addr(tx1_addr),
    .req0_level(req0_level), .req1_level(req1_level),
    .req0_overflow(req0_overflow), .req1_overflow(req1_overflow),
    .ovf_clear(ovf_clear), .tx0_timeout(tx0_timeout), .tx1_timeout(tx1_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // engine model: busy rises the cycle after the pulse and lasts bl cycles
  always @(posedge clk) begin
    if (tx0_cmd_send && !noack[0]) bcnt[0] <= bl[0];
    else if (bcnt[0] > 0) bcnt[0] <= bcnt[0] - 1;
    if (tx1_cmd_send && !noack[1]) bcnt[1] <= bl[1];
    else if (bcnt[1] > 0) bcnt[1] <= bcnt[1] - 1;
  end
  assign tx0_busy = bcnt[0] != 0;
  assign tx1_busy = bcnt[1] != 0;

  always @(negedge clk) begin
    if (tx0_cmd_send) log_q.push_back(disp_t'{1'b0, tx0_addr, cyc});
    if (tx1_cmd_send) log_q.push_back(disp_t'{1'b1, tx1_addr, cyc});
    if (tx0_timeout) begin to0_n++; to0_cyc = cyc; end
    if (tx1_timeout) to1_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [24:0] a);
    if (r == 0) begin req0_cmd_send = 1'b1; req0_addr = a; end
    else begin req1_cmd_send = 1'b1; req1_addr = a; end
    step(1);
    req0_cmd_send = 1'b0;
    req1_cmd_send = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_send", {tx1_cmd_send, tx0_cmd_send}, 0);
    chk("rst_addr", tx0_addr | tx1_addr, 0);
    chk("rst_level", {req1_level, req0_level}, 0);
    chk("rst_flags", {req1_overflow, req0_overflow, tx1_timeout, tx0_timeout}, 0);
    rst_n = 1'b1;
    step(1);
    // gating: nothing leaves while only one of the two enables is up
    push(0, 'h10); push(0, 'h20); push(0, 'h30);
    step(2);
    chk("gate_level", req0_level, 3);
    mac_inited = 1'b1;
    step(3);
    chk("gate_nodisp", log_q.size(), 0);
    cal_success = 1'b1;
    step(30);
    chk("gate_n", log_q.size(), 3);
    chk("gate_d0", {log_q[0].ch, log_q[0].addr}, {1'b0, 25'h10});
    chk("gate_d1", {log_q[1].ch, log_q[1].addr}, {1'b1, 25'h20});
    chk("gate_d2", {log_q[2].ch, log_q[2].addr}, {1'b0, 25'h30});
    chk("gate_gap01", log_q[1].cyc - log_q[0].cyc, 1);
    chk("gate_redisp", log_q[2].cyc - log_q[0].cyc, 8);
    chk("gate_empty", req0_level, 0);
    // round-robin: pointer sits on req1 after serving req0 last
    log_q.delete();
    cal_success = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req0_cmd_send = 1'b1; req0_addr = 25'('h100 + i);
      req1_cmd_send = 1'b1; req1_addr = 25'('h200 + i);
      step(1);
    end
    req0_cmd_send = 1'b0; req1_cmd_send = 1'b0;
    cal_success = 1'b1;
    step(60);
    chk("rr_n", log_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("rr_%0d", i), log_q[i].addr, exp_rr[i]);
    // overflow and clear priority
    log_q.delete();
    cal_success = 1'b0;
    for (int i = 0; i < 5; i++) push(1, 25'('h300 + i));
    chk("ovf_level", req1_level, 4);
    chk("ovf_flags", {req1_overflow, req0_overflow}, 2'b10);
    ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
    chk("ovf_clr", req1_overflow, 0);
    ovf_clear = 1'b1; push(1, 'h305); ovf_clear = 1'b0;
    chk("ovf_clr_prio", {req1_overflow, req1_level}, {1'b0, 3'd4});
    push(1, 'h306);
    chk("ovf_reset", req1_overflow, 1);
    ovf_clear = 1'b1; step(1); ovf_clear = 1'b0;
    cal_success = 1'b1;
    step(40);
    chk("ovf_n", log_q.size(), 4);
    chk("ovf_last", log_q[3].addr, 'h303);
    chk("ovf_drained", req1_level, 0);
    // full FIFO push with same-cycle pop, then en drops after one cycle
    log_q.delete();
    cal_success = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 25'('h400 + i));
    chk("fp_full", req0_level, 4);
    cal_success = 1'b1;
    push(0, 'h404);
    cal_success = 1'b0;
    chk("fp_level", {req0_overflow, req0_level}, {1'b0, 3'd4});
    step(5);
    chk("fp_one", log_q.size(), 1);
    chk("fp_first", log_q[0].addr, 'h400);
    chk("fp_hold", req0_level, 4);
    cal_success = 1'b1;
    step(40);
    chk("fp_n", log_q.size(), 5);
    chk("fp_last", log_q[4].addr, 'h404);
    // timeout: tx0 never acks, tx1 stays busy so the third command must wait for tx0
    log_q.delete();
    to0_n = 0; to1_n = 0;
    bl[1] = 40; noack[0] = 1'b1;
    cal_success = 1'b0;
    push(0, 'h500); push(0, 'h501); push(0, 'h502);
    cal_success = 1'b1;
    step(10);
    noack[0] = 1'b0;
    step(30);
    chk("to_cnt", {to1_n[15:0], to0_n[15:0]}, 1);
    chk("to_d0", {log_q[0].ch, log_q[0].addr}, {1'b0, 25'h500});
    chk("to_d1", {log_q[1].ch, log_q[1].addr}, {1'b1, 25'h501});
    chk("to_d2", {log_q[2].ch, log_q[2].addr}, {1'b0, 25'h502});
    chk("to_lat", to0_cyc - log_q[0].cyc, 15);
    chk("to_redisp", log_q[2].cyc - to0_cyc, 2);
    // reset while tx1 is busy and two commands are queued
    step(30);
    log_q.delete();
    bl[0] = 50; bl[1] = 50;
    cal_success = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 25'('h600 + i));
    cal_success = 1'b1;
    step(5);
    chk("rm_pre", {log_q.size() == 2, req0_level}, {1'b1, 3'd2});
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("rm_level", {req1_level, req0_level}, 0);
    chk("rm_out", {tx1_cmd_send, tx0_cmd_send, tx1_addr, tx0_addr} != 0, 0);
    chk("rm_flags", {req1_overflow, req0_overflow}, 0);
    step(5);
    chk("rm_quiet", log_q.size(), 2);
    pc = cyc;
    push(0, 'h700);
    step(5);
    chk("rm_resume", {log_q[2].ch, log_q[2].addr}, {1'b0, 25'h700});
    chk("rm_latency", log_q[2].cyc - pc, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
